// File: rtl/neogeo_bus_pkg.sv
// Shared types and constants for the 68000 bus initiator.
// State encoding, byte-enable lanes and the default wait-pair limit.
package neogeo_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_SW,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_NULL
    } bus_state_t;

    localparam int BE_UDS = 1;
    localparam int BE_LDS = 0;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/m68k_wait_timer.sv
// Wait-state pair counter for the 68000 bus initiator.
// Samples once per pair so the CPU clock phase is preserved.
module m68k_wait_timer
    import neogeo_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_sample,
    output logic o_timeout
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic       r_phase;
    logic [7:0] r_pairs;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_phase <= 1'b0;
            r_pairs <= 8'd0;
        end else if (i_en) begin
            r_phase <= ~r_phase;
            if (r_phase && (r_pairs != 8'hFF)) begin
                r_pairs <= r_pairs + 8'd1;
            end
        end
    end

    assign o_sample  = i_en & r_phase;
    // Fires on the sample cycle that would complete pair number TIMEOUT.
    assign o_timeout = o_sample & (r_pairs >= LAST);

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus initiator driving S0..S7 timing from word commands.
// Stands in for the CPU so cart, memcard and system decode can be exercised.
module m68k_bus_master
    import neogeo_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_RW,
    input  logic [22:0] CMD_ADDR,
    input  logic [1:0]  CMD_BE,
    input  logic [15:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [22:0] M68K_ADDR,
    output logic        M68K_RW,
    output logic        nAS,
    output logic        nUDS,
    output logic        nLDS,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        nDTACK,
    input  logic        nBERR
);

    bus_state_t  r_state;
    bus_state_t  w_next;
    logic        r_rw;
    logic [22:0] r_addr;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_err;

    logic w_accept;
    logic w_set_err;
    logic w_sample;
    logic w_timeout;
    logic w_as;
    logic w_strb;
    logic w_rwl;
    logic w_oe;

    assign w_accept = CMD_VALID && (r_state == ST_IDLE);

    m68k_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (CLK_24M),
        .i_rst     (RESET),
        .i_clr     (r_state == ST_S4),
        .i_en      (r_state == ST_SW),
        .o_sample  (w_sample),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_rw    <= 1'b1;
            r_addr  <= 23'd0;
            r_be    <= 2'b00;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rw    <= CMD_RW;
                r_addr  <= CMD_ADDR;
                r_be    <= CMD_BE;
                r_wdata <= CMD_WDATA;
                r_err   <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (r_state == ST_S6) begin
                r_rdata <= (r_rw && !r_err) ? DATA_IN : 16'd0;
            end else if (r_state == ST_NULL) begin
                r_rdata <= 16'd0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    w_next = (CMD_BE == 2'b00) ? ST_NULL : ST_S0;
                end
            end
            ST_S0: w_next = ST_S1;
            ST_S1: w_next = ST_S2;
            ST_S2: w_next = ST_S3;
            ST_S3: w_next = ST_S4;
            ST_S4: begin
                if (!nBERR) begin
                    w_set_err = 1'b1;
                    w_next    = ST_S5;
                end else if (!nDTACK) begin
                    w_next = ST_S5;
                end else begin
                    w_next = ST_SW;
                end
            end
            ST_SW: begin
                if (w_sample) begin
                    if (!nBERR) begin
                        w_set_err = 1'b1;
                        w_next    = ST_S5;
                    end else if (!nDTACK) begin
                        w_next = ST_S5;
                    end else if (w_timeout) begin
                        w_set_err = 1'b1;
                        w_next    = ST_S5;
                    end
                end
            end
            ST_S5:   w_next = ST_S6;
            ST_S6:   w_next = ST_S7;
            ST_S7:   w_next = ST_IDLE;
            ST_NULL: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Reads raise strobes with nAS; writes wait until data is on the bus.
    always_comb begin
        w_as   = 1'b0;
        w_strb = 1'b0;
        w_rwl  = 1'b0;
        w_oe   = 1'b0;
        unique case (r_state)
            ST_S2: begin
                w_as   = 1'b1;
                w_rwl  = 1'b1;
                w_strb = r_rw;
            end
            ST_S3: begin
                w_as   = 1'b1;
                w_rwl  = 1'b1;
                w_strb = r_rw;
                w_oe   = 1'b1;
            end
            ST_S4, ST_SW, ST_S5, ST_S6: begin
                w_as   = 1'b1;
                w_rwl  = 1'b1;
                w_strb = 1'b1;
                w_oe   = 1'b1;
            end
            ST_S7: begin
                w_rwl = 1'b1;
                w_oe  = 1'b1;
            end
            default: begin
                w_as = 1'b0;
            end
        endcase
    end

    assign CMD_READY = (r_state == ST_IDLE);
    assign RSP_VALID = (r_state == ST_S7) || (r_state == ST_NULL);
    assign RSP_ERR   = (r_state == ST_NULL) || ((r_state == ST_S7) && r_err);
    assign RSP_RDATA = r_rdata;

    assign M68K_ADDR = r_addr;
    assign M68K_RW   = ~(w_rwl & ~r_rw);
    assign nAS       = ~w_as;
    assign nUDS      = ~(w_strb & r_be[BE_UDS]);
    assign nLDS      = ~(w_strb & r_be[BE_LDS]);
    assign DATA_OE   = w_oe & ~r_rw;
    assign DATA_OUT  = DATA_OE ? r_wdata : 16'd0;

endmodule
